traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
//   Receive-side checker for the 3-bit one-hot traffic light bus (RED=100, YELLOW=010, GREEN=001).
//   Samples the bus each clock, decodes the active phase and measures phase dwell.
//   Flags illegal codes and illegal phase order; counts completed RED->GREEN->YELLOW->RED cycles.
//   Sits beside the light controller in the top level; its outputs feed the status/fault logic.
// PARAMETERS
//   CNT_W      16    width of dwell counter (saturating)
//   CYC_W      8     width of completed-cycle counter (wrapping)
//   MIN_DWELL  1     min legal cycles per phase (used only with TLM_DWELL_CHECK_EN)
//   MAX_DWELL  1000  max legal cycles per phase (used only with TLM_DWELL_CHECK_EN)
// PORTS
//   clk          in   1      clock; all logic on posedge
//   reset        in   1      synchronous reset, active-low (reset==0 resets on posedge clk)
//   light        in   3      observed light code
//   clr_fault    in   1      clears sticky fault
//   phase        out  2      decoded phase: 0=NONE 1=RED 2=GREEN 3=YELLOW
//   phase_valid  out  1      1 while tracking a legal phase
//   dwell        out  CNT_W  cycles current phase has been observed (1 on first cycle)
//   cycles       out  CYC_W  completed full cycles
//   code_err     out  1      1-cycle pulse: light not in {100,010,001}
//   seq_err      out  1      1-cycle pulse: illegal phase transition
//   dwell_err    out  1      1-cycle pulse: dwell violation (0 if feature off)
//   fault        out  1      sticky OR of all error pulses
// BEHAVIOUR
//   - All outputs registered; response to a sample appears 1 clk after the posedge that samples it.
//   - Reset (reset==0): state=INIT, phase=0, phase_valid=0, dwell=0, cycles=0, all err=0, fault=0.
//     Reset mid-cycle discards all history; the first sample afterwards is treated as from INIT.
//   - FSM states: INIT, RED, GREEN, YELLOW.
//     INIT: legal code -> matching state, dwell=1, no seq_err. Illegal code -> stay INIT, code_err.
//     Same code as current state -> stay; dwell+1, saturating at 2**CNT_W-1.
//     Legal successors: RED->GREEN, GREEN->YELLOW, YELLOW->RED; on each, dwell=1.
//       YELLOW->RED also increments cycles, wrapping from 2**CYC_W-1 to 0.
//     Other legal code (e.g. RED->YELLOW, GREEN->RED): seq_err pulse; adopt the new phase, dwell=1,
//       cycles unchanged.
//     Illegal code (000, 011, 101, 110, 111) from any state: code_err pulse; go to INIT;
//       phase=0, phase_valid=0, dwell=0. code_err takes priority; seq_err is never asserted
//       in the same cycle.
//   - fault: set on any err pulse, cleared by clr_fault. If a new error and clr_fault occur in
//     the same cycle, fault stays 1.
// CONFIGURATION
//   TLM_DWELL_CHECK_EN defined:
//     - On leaving a phase with dwell < MIN_DWELL: dwell_err pulse, in the same cycle as any seq_err.
//     - While in a phase: dwell_err pulse exactly once, in the cycle dwell first equals MAX_DWELL.
//     - No dwell check is made when leaving via code_err or when leaving INIT.
//   TLM_DWELL_CHECK_EN undefined:
//     - dwell_err is tied to 0; MIN_DWELL and MAX_DWELL are unused.
//     - dwell counting and the dwell output still operate.
// STRUCTURE
//   - Shared package traffic_light_pkg:
//     - light code constants LIGHT_RED/LIGHT_YELLOW/LIGHT_GREEN;
//     - phase encoding PH_NONE/PH_RED/PH_GREEN/PH_YELLOW;
//     - monitor state encoding.
//     The controller uses the same light constants.
//   - Sub-module tl_dwell_timer: saturating dwell counter plus MIN/MAX compare. Its compare logic
//     is present only under TLM_DWELL_CHECK_EN.
// TESTING
//   1. Reset, then drive RED,GREEN,YELLOW,RED with 1 clk each -> phase 1,2,3,1; dwell=1 each;
//      cycles=1 after the final RED; no errors.
//   2. Hold GREEN for 5 clks -> dwell counts 1..5. With CNT_W=3, hold for 10 clks -> dwell sticks at 7.
//   3. RED then YELLOW -> seq_err for 1 clk; fault=1; phase=3. Then clr_fault -> fault=0.
//   4. GREEN then 011 -> code_err, phase=0, phase_valid=0. Then YELLOW -> phase=3, no seq_err.
//   5. cycles=2**CYC_W-1 plus one more full cycle -> cycles=0. Also: reset low mid-YELLOW ->
//      all outputs 0 next clk.
//   6. TLM_DWELL_CHECK_EN, MIN=2, MAX=4: RED 1 clk then GREEN -> dwell_err; hold GREEN ->
//      dwell_err once, at dwell=4.
//      Macro undefined, same stimulus -> dwell_err stays 0.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: light codes, phase encoding and monitor state shared by the traffic light blocks
package traffic_light_pkg;
   localparam logic [2:0] LIGHT_RED    = 3'b100;
   localparam logic [2:0] LIGHT_YELLOW = 3'b010;
   localparam logic [2:0] LIGHT_GREEN  = 3'b001;
   localparam logic [1:0] PH_NONE   = 2'd0;
   localparam logic [1:0] PH_RED    = 2'd1;
   localparam logic [1:0] PH_GREEN  = 2'd2;
   localparam logic [1:0] PH_YELLOW = 2'd3;
   // State values equal the phase encoding so the phase output is the state register itself
   typedef enum logic [1:0] {
      ST_INIT   = PH_NONE,
      ST_RED    = PH_RED,
      ST_GREEN  = PH_GREEN,
      ST_YELLOW = PH_YELLOW
   } tlm_state_e;
   function automatic tlm_state_e decode_light(input logic [2:0] l);
      return l == LIGHT_RED ? ST_RED : l == LIGHT_GREEN ? ST_GREEN : l == LIGHT_YELLOW ? ST_YELLOW : ST_INIT;
   endfunction
   function automatic tlm_state_e successor(input tlm_state_e s);
      return s == ST_RED ? ST_GREEN : s == ST_GREEN ? ST_YELLOW : s == ST_YELLOW ? ST_RED : ST_INIT;
   endfunction
endpackage

// File: rtl/tl_dwell_timer.sv
// tl_dwell_timer: saturating phase dwell counter; MIN/MAX dwell compare only when TLM_DWELL_CHECK_EN is defined
module tl_dwell_timer
   import traffic_light_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int MIN_DWELL = 1,
   parameter int MAX_DWELL = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             zero,
   input  logic             load,
   input  logic             leave,
   output logic [CNT_W-1:0] dwell,
   output logic             viol
);
   logic [CNT_W-1:0] dwell_n;
   always_comb dwell_n = zero ? '0 : load ? CNT_W'(1) : &dwell ? dwell : dwell + 1'b1;
   always_ff @(posedge clk) dwell <= !reset ? '0 : dwell_n;
`ifdef TLM_DWELL_CHECK_EN
   // A MAX hit is flagged only on the cycle the count first reaches it, so saturation at MAX fires once
   always_comb viol = (leave && dwell < CNT_W'(MIN_DWELL)) ||
                      (!zero && dwell_n == CNT_W'(MAX_DWELL) && (load || dwell != CNT_W'(MAX_DWELL)));
`else
   logic unused_cfg;
   assign unused_cfg = leave ^ (MIN_DWELL > MAX_DWELL);
   assign viol = 1'b0;
`endif
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks the one-hot light bus for illegal codes, phase order and dwell.
// Dwell limit checking is built only when TLM_DWELL_CHECK_EN is defined.
module traffic_light_monitor
   import traffic_light_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int CYC_W     = 8,
   parameter int MIN_DWELL = 1,
   parameter int MAX_DWELL = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       light,
   input  logic             clr_fault,
   output logic [1:0]       phase,
   output logic             phase_valid,
   output logic [CNT_W-1:0] dwell,
   output logic [CYC_W-1:0] cycles,
   output logic             code_err,
   output logic             seq_err,
   output logic             dwell_err,
   output logic             fault
);
   tlm_state_e state, state_n;
   logic same, leave, code_n, seq_n, wrap_n, viol;
   always_comb begin
      state_n = decode_light(light);
      code_n  = state_n == ST_INIT;
      same    = !code_n && state_n == state;
      leave   = !code_n && !same && state != ST_INIT;
      seq_n   = leave && state_n != successor(state);
      wrap_n  = state == ST_YELLOW && state_n == ST_RED;
   end
   tl_dwell_timer #(.CNT_W(CNT_W), .MIN_DWELL(MIN_DWELL), .MAX_DWELL(MAX_DWELL)) u_timer (
      .clk  (clk),
      .reset(reset),
      .zero (code_n),
      .load (!code_n && !same),
      .leave(leave),
      .dwell(dwell),
      .viol (viol)
   );
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_INIT;
         phase_valid <= 1'b0;
         cycles      <= '0;
         code_err    <= 1'b0;
         seq_err     <= 1'b0;
         dwell_err   <= 1'b0;
         fault       <= 1'b0;
      end else begin
         state       <= state_n;
         phase_valid <= !code_n;
         cycles      <= cycles + CYC_W'(wrap_n);
         code_err    <= code_n;
         seq_err     <= seq_n;
         dwell_err   <= viol;
         fault       <= (fault && !clr_fault) || code_n || seq_n || viol;
      end
   end
   assign phase = state;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed and random stimulus against a phase-level reference model
module tb_traffic_light_monitor;
   localparam int CNT_W = 3, CYC_W = 4, MIN_D = 2, MAX_D = 4;
   localparam int DMAX = 2**CNT_W - 1, CYC_MOD = 2**CYC_W;
`ifdef TLM_DWELL_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   logic clk, reset, clr_fault, phase_valid, code_err, seq_err, dwell_err, fault;
   logic [2:0] light;
   logic [1:0] phase;
   logic [CNT_W-1:0] dwell;
   logic [CYC_W-1:0] cycles;
   int n_chk = 0, n_fail = 0;
   int m_ph = 0, m_dw = 0, m_cyc = 0;
   bit m_fault = 0, e_code = 0, e_seq = 0, e_derr = 0;

   traffic_light_monitor #(.CNT_W(CNT_W), .CYC_W(CYC_W), .MIN_DWELL(MIN_D), .MAX_DWELL(MAX_D)) dut (
      .clk(clk), .reset(reset), .light(light), .clr_fault(clr_fault), .phase(phase),
      .phase_valid(phase_valid), .dwell(dwell), .cycles(cycles), .code_err(code_err),
      .seq_err(seq_err), .dwell_err(dwell_err), .fault(fault)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // phase numbers: 1=RED 2=GREEN 3=YELLOW, successor of p is p%3+1
   function automatic int ph_of(input logic [2:0] l);
      return l == 3'b100 ? 1 : l == 3'b001 ? 2 : l == 3'b010 ? 3 : 0;
   endfunction
   function automatic logic [2:0] code_of(input int p);
      return p == 1 ? 3'b100 : p == 2 ? 3'b001 : p == 3 ? 3'b010 : 3'b000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model(input logic rst_n, input logic [2:0] l, input logic c);
      int np, pd;
      e_code = 0; e_seq = 0; e_derr = 0;
      if (!rst_n) begin
         m_ph = 0; m_dw = 0; m_cyc = 0; m_fault = 0;
         return;
      end
      np = ph_of(l);
      pd = m_dw;
      if (np == 0) begin
         e_code = 1; m_ph = 0; m_dw = 0;
      end else if (np == m_ph) begin
         m_dw = m_dw < DMAX ? m_dw + 1 : DMAX;
         e_derr = CHK && m_dw == MAX_D && pd != MAX_D;
      end else begin
         if (m_ph != 0) begin
            e_seq = np != m_ph % 3 + 1;
            e_derr = CHK && pd < MIN_D;
            if (m_ph == 3 && np == 1) m_cyc = (m_cyc + 1) % CYC_MOD;
         end
         m_ph = np; m_dw = 1;
         if (CHK && MAX_D == 1) e_derr = 1;
      end
      m_fault = (m_fault && !c) || e_code || e_seq || e_derr;
   endtask

   task automatic check_all();
      chk("phase", phase, m_ph);
      chk("phase_valid", phase_valid, m_ph != 0);
      chk("dwell", dwell, m_dw);
      chk("cycles", cycles, m_cyc);
      chk("code_err", code_err, e_code);
      chk("seq_err", seq_err, e_seq);
      chk("dwell_err", dwell_err, e_derr);
      chk("fault", fault, m_fault);
   endtask

   task automatic step(input logic rst_n, input logic [2:0] l, input logic c);
      @(negedge clk);
      reset = rst_n; light = l; clr_fault = c;
      @(posedge clk);
      model(rst_n, l, c);
      #1 check_all();
   endtask

   initial begin
      int r, p;
      reset = 0; light = 3'b000; clr_fault = 0;
      step(0, 3'b100, 0);
      step(0, 3'b111, 0);
      // normal cycle
      step(1, 3'b100, 0); step(1, 3'b001, 0); step(1, 3'b010, 0); step(1, 3'b100, 0);
      chk("t1_cycles", cycles, 1);
      chk("t1_fault", fault, 0);
      // hold GREEN past saturation
      for (int i = 0; i < 10; i++) step(1, 3'b001, 0);
      chk("t2_sat", dwell, 7);
      // out-of-order RED->YELLOW, then clear
      step(1, 3'b010, 0); step(1, 3'b100, 0); step(1, 3'b010, 0);
      chk("t3_seq", seq_err, 1);
      chk("t3_phase", phase, 3);
      chk("t3_fault", fault, 1);
      step(1, 3'b010, 1);
      chk("t3_clr", fault, 0);
      // illegal code then re-entry from INIT
      step(1, 3'b100, 0); step(1, 3'b001, 0); step(1, 3'b011, 0);
      chk("t4_code", code_err, 1);
      chk("t4_valid", phase_valid, 0);
      step(1, 3'b010, 0);
      chk("t4_phase", phase, 3);
      chk("t4_noseq", seq_err, 0);
      // cycle counter wrap
      step(0, 3'b000, 0);
      step(1, 3'b100, 0);
      for (int i = 0; i < CYC_MOD; i++) begin
         step(1, 3'b001, 0); step(1, 3'b010, 0); step(1, 3'b100, 0);
      end
      chk("t5_wrap", cycles, 0);
      // reset mid-YELLOW
      step(1, 3'b001, 0); step(1, 3'b010, 0); step(1, 3'b010, 0);
      step(0, 3'b010, 0);
      chk("t5_rst_dwell", dwell, 0);
      chk("t5_rst_phase", phase, 0);
      // short RED then GREEN held past MAX
      step(1, 3'b100, 0); step(1, 3'b001, 0);
      chk("t6_min", dwell_err, CHK);
      for (int i = 0; i < 6; i++) step(1, 3'b001, 0);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 15);
         p = m_ph == 0 ? 1 : m_ph;
         step($urandom_range(0, 59) != 0,
              r < 8 ? code_of(m_ph == 0 ? 1 : m_ph % 3 + 1) :
              r < 11 ? code_of(p) :
              r < 14 ? code_of($urandom_range(1, 3)) : 3'($urandom_range(0, 7)),
              $urandom_range(0, 7) == 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
